// File: rtl/present_cbc_enc.sv
// PRESENT-80 block encryption in CBC mode with valid/ready streaming.
// encrypt_v1 is the combinational 31-round cipher; present_cbc_enc wraps it with chaining state.

module encrypt_v1 (
  input  logic [79:0] K,
  input  logic [63:0] M,
  output logic [63:0] C
);

  // Nibble n of this constant is S(n)
  localparam logic [63:0] SboxTable = 64'h21748FE3DA09B65C;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    return SboxTable[{x, 2'b00} +: 4];
  endfunction

  logic [63:0] st;
  logic [63:0] sb_out;
  logic [63:0] pl;
  logic [79:0] rk;

  always_comb begin
    st     = M;
    rk     = K;
    sb_out = '0;
    pl     = '0;
    for (int r = 1; r < 32; r++) begin
      st = st ^ rk[79:16];
      for (int j = 0; j < 16; j++) begin
        sb_out[4*j +: 4] = sbox(st[4*j +: 4]);
      end
      // Bit i moves to 16*i mod 63; bit 63 stays put
      for (int i = 0; i < 63; i++) begin
        pl[(16*i) % 63] = sb_out[i];
      end
      pl[63] = sb_out[63];
      st     = pl;
      rk            = {rk[18:0], rk[79:19]};
      rk[79:76]     = sbox(rk[79:76]);
      rk[19:15]     = rk[19:15] ^ 5'(r);
    end
    C = st ^ rk[79:16];
  end

endmodule

module present_cbc_enc #(
  parameter int unsigned b = 64,
  parameter int unsigned k = 80,
  parameter int unsigned w = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         init,
  input  logic [k-1:0] key_in,
  input  logic [b-1:0] iv_in,
  input  logic         m_valid,
  output logic         m_ready,
  input  logic [b-1:0] m_data,
  output logic         c_valid,
  input  logic         c_ready,
  output logic [b-1:0] c_data,
  output logic         keyed,
  output logic [w-1:0] blk_cnt
);

  typedef enum logic {StUnkeyed, StRun} state_e;

  state_e       state_q, state_d;
  logic [k-1:0] key_q, key_d;
  logic [b-1:0] x_q, x_d;
  logic [b-1:0] ob_q, ob_d;
  logic         c_valid_q, c_valid_d;
  logic [w-1:0] blk_cnt_q, blk_cnt_d;
  logic [b-1:0] enc_out;
  logic         accept;

  encrypt_v1 u_cipher (
    .K (key_q),
    .M (m_data ^ x_q),
    .C (enc_out)
  );

  always_comb begin
    state_d   = state_q;
    key_d     = key_q;
    x_d       = x_q;
    ob_d      = ob_q;
    c_valid_d = c_valid_q;
    blk_cnt_d = blk_cnt_q;
    m_ready   = (state_q == StRun) & ~init & (~c_valid_q | c_ready);
    accept    = m_valid & m_ready;

    if (init) begin
      // Restart the message; any buffered ciphertext is dropped
      state_d   = StRun;
      key_d     = key_in;
      x_d       = iv_in;
      ob_d      = '0;
      c_valid_d = 1'b0;
      blk_cnt_d = '0;
    end else if (accept) begin
      ob_d      = enc_out;
      x_d       = enc_out;
      c_valid_d = 1'b1;
      if (blk_cnt_q != {w{1'b1}}) begin
        blk_cnt_d = blk_cnt_q + w'(1);
      end
    end else if (c_valid_q && c_ready) begin
      c_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StUnkeyed;
      key_q     <= '0;
      x_q       <= '0;
      ob_q      <= '0;
      c_valid_q <= 1'b0;
      blk_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      key_q     <= key_d;
      x_q       <= x_d;
      ob_q      <= ob_d;
      c_valid_q <= c_valid_d;
      blk_cnt_q <= blk_cnt_d;
    end
  end

  assign c_valid = c_valid_q;
  assign c_data  = ob_q;
  assign keyed   = (state_q == StRun);
  assign blk_cnt = blk_cnt_q;

endmodule

// File: tb/tb_present_cbc_enc.sv
// Scoreboard bench for present_cbc_enc using published PRESENT-80 vectors.
// Stimulus changes 1 time unit after posedge; outputs are sampled on negedge.

module tb_present_cbc_enc;

  localparam logic [63:0] C00    = 64'h5579c1387b228445; // key 0,  block 0
  localparam logic [63:0] C0F    = 64'ha112ffc72f68417b; // key 0,  block all-ones
  localparam logic [63:0] CF0    = 64'he72c46c0f5945049; // key all-ones, block 0
  localparam logic [63:0] ONES64 = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [79:0] ONES80 = 80'hFFFF_FFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        init;
  logic [79:0] key_in;
  logic [63:0] iv_in;
  logic        m_valid;
  logic        m_ready;
  logic [63:0] m_data;
  logic        c_valid;
  logic        c_ready;
  logic [63:0] c_data;
  logic        keyed;
  logic [15:0] blk_cnt;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  bit          mon_en  = 1'b1;
  logic [63:0] sb[$];
  int          pop_cyc[$];

  always #5 clk = ~clk;

  present_cbc_enc dut (
    .clk     (clk),
    .rst     (rst),
    .init    (init),
    .key_in  (key_in),
    .iv_in   (iv_in),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .c_valid (c_valid),
    .c_ready (c_ready),
    .c_data  (c_data),
    .keyed   (keyed),
    .blk_cnt (blk_cnt)
  );

  // Load key/IV; starts and ends 1 unit after a posedge
  task automatic do_init(input logic [79:0] key, input logic [63:0] iv);
    init   = 1'b1;
    key_in = key;
    iv_in  = iv;
    @(posedge clk); #1;
    init   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Offer one block and push its expected ciphertext once it is accepted
  task automatic send(input logic [63:0] m, input logic [63:0] exp);
    bit got = 1'b0;
    m_valid = 1'b1;
    m_data  = m;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (m_ready === 1'b1) begin
        got = 1'b1;
        sb.push_back(exp);
      end
      @(posedge clk); #1;
      if (got) break;
    end
    m_valid = 1'b0;
    n_tests++;
    if (!got) begin
      n_fail++;
      $display("FAIL send_timeout: block %h accepted=0 required=1", m);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; init = 1'b0; key_in = '0; iv_in = '0;
    m_valid = 1'b0; m_data = '0; c_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({keyed, c_valid, m_ready} !== 3'b000 || c_data !== 64'h0 || blk_cnt !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_state: keyed=%b c_valid=%b m_ready=%b c_data=%h blk_cnt=%0d required all 0",
               keyed, c_valid, m_ready, c_data, blk_cnt);
    end
    @(posedge clk); #1;
    rst     = 1'b0;
    m_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_tests++;
      if ({keyed, c_valid, m_ready} !== 3'b000 || blk_cnt !== 16'h0) begin
        n_fail++;
        $display("FAIL unkeyed_idle: cycle %0d keyed=%b c_valid=%b m_ready=%b blk_cnt=%0d required 0",
                 i, keyed, c_valid, m_ready, blk_cnt);
      end
    end
    @(posedge clk); #1;
    m_valid = 1'b0;
  endtask

  task automatic test_ecb;
    c_ready = 1'b1;
    do_init(80'h0, 64'h0);
    @(negedge clk);
    n_tests++;
    if (keyed !== 1'b1 || c_data !== 64'h0 || blk_cnt !== 16'h0) begin
      n_fail++;
      $display("FAIL after_init: keyed=%b c_data=%h blk_cnt=%0d required 1/0/0",
               keyed, c_data, blk_cnt);
    end
    @(posedge clk); #1;
    send(64'h0, C00);
    @(negedge clk);
    n_tests++;
    if (c_valid !== 1'b1 || blk_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL ecb_latency: c_valid=%b blk_cnt=%0d required 1/1", c_valid, blk_cnt);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_tests++;
    if (c_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ecb_drain: c_valid=%b required 0", c_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int a, z;
    c_ready = 1'b1;
    do_init(80'h0, 64'h0);
    send(64'h0, C00);
    send(C00, C00);
    idle(2);
    n_tests++;
    if (blk_cnt !== 16'd2) begin
      n_fail++;
      $display("FAIL b2b_count: blk_cnt=%0d required 2", blk_cnt);
    end
    n_tests++;
    if (pop_cyc.size() < 2) begin
      n_fail++;
      $display("FAIL b2b_outputs: seen=%0d required >=2", pop_cyc.size());
    end else begin
      z = pop_cyc[pop_cyc.size()-1];
      a = pop_cyc[pop_cyc.size()-2];
      if (z - a !== 1) begin
        n_fail++;
        $display("FAIL b2b_bubble: output gap=%0d cycles required 1", z - a);
      end
    end
  endtask

  task automatic test_iv;
    c_ready = 1'b1;
    do_init(ONES80, ONES64);
    send(ONES64, CF0);
    idle(1);
    do_init(80'h0, ONES64);
    send(64'h0, C0F);
    idle(1);
  endtask

  task automatic test_backpressure;
    c_ready = 1'b1;
    do_init(80'h0, 64'h0);
    send(64'h0, C00);
    c_ready = 1'b0;
    m_valid = 1'b1;
    m_data  = C00 ^ ONES64;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_tests++;
      if (m_ready !== 1'b0 || c_valid !== 1'b1 || c_data !== C00) begin
        n_fail++;
        $display("FAIL backpressure: cycle %0d m_ready=%b c_valid=%b c_data=%h required 0/1/%h",
                 i, m_ready, c_valid, c_data, C00);
      end
    end
    @(posedge clk); #1;
    c_ready = 1'b1;
    send(C00 ^ ONES64, C0F);
    @(negedge clk);
    n_tests++;
    if (c_valid !== 1'b1 || blk_cnt !== 16'd2) begin
      n_fail++;
      $display("FAIL drain_and_accept: c_valid=%b blk_cnt=%0d required 1/2", c_valid, blk_cnt);
    end
    @(posedge clk); #1;
    idle(1);
  endtask

  task automatic test_init_mid;
    c_ready = 1'b1;
    do_init(80'h0, 64'h0);
    send(64'h0, C00);
    c_ready = 1'b0;
    idle(1);
    init   = 1'b1;
    key_in = 80'h0;
    iv_in  = ONES64;
    @(negedge clk);
    n_tests++;
    if (m_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL init_mready: m_ready=%b required 0", m_ready);
    end
    @(posedge clk); #1;
    init = 1'b0;
    sb.delete();
    @(negedge clk);
    n_tests++;
    if (c_valid !== 1'b0 || blk_cnt !== 16'h0 || c_data !== 64'h0 || keyed !== 1'b1) begin
      n_fail++;
      $display("FAIL init_midstream: c_valid=%b blk_cnt=%0d c_data=%h keyed=%b required 0/0/0/1",
               c_valid, blk_cnt, c_data, keyed);
    end
    @(posedge clk); #1;
    c_ready = 1'b1;
    send(64'h0, C0F);
    idle(1);
    // Leave a block pending, then reset between clock edges
    c_ready = 1'b0;
    send(64'h1234, 64'h0);
    #2 rst = 1'b1;
    #1;
    sb.delete();
    n_tests++;
    if ({keyed, c_valid, m_ready} !== 3'b000 || c_data !== 64'h0 || blk_cnt !== 16'h0) begin
      n_fail++;
      $display("FAIL async_reset: keyed=%b c_valid=%b m_ready=%b c_data=%h blk_cnt=%0d required 0",
               keyed, c_valid, m_ready, c_data, blk_cnt);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    c_ready = 1'b1;
    idle(1);
  endtask

  task automatic test_saturation;
    c_ready = 1'b1;
    do_init(80'h0, 64'h0);
    mon_en  = 1'b0;
    m_valid = 1'b1;
    m_data  = 64'h0;
    idle(65540);
    m_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (blk_cnt !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL blk_cnt_saturate: blk_cnt=%h required ffff", blk_cnt);
    end
    @(posedge clk); #1;
    idle(2);
    mon_en = 1'b1;
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        cyc++;
        if (mon_en && rst === 1'b0 && c_valid === 1'b1 && c_ready === 1'b1) begin
          n_tests++;
          if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_output: c_data=%h required no output", c_data);
          end else begin
            logic [63:0] exp;
            exp = sb.pop_front();
            pop_cyc.push_back(cyc);
            if (c_data !== exp) begin
              n_fail++;
              $display("FAIL ciphertext: c_data=%h required %h", c_data, exp);
            end
          end
        end
      end
    join_none

    test_reset();
    test_ecb();
    test_back_to_back();
    test_iv();
    test_backpressure();
    test_init_mid();
    test_saturation();

    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL outputs_missing: pending=%0d required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
